// File: rtl/fft_pkg.sv
// Shared types, Q8 twiddle tables and round/narrow helpers for the streaming FFT stages.
package fft_pkg;

    localparam int N_MAX = 64;
    localparam int TW    = 10;

    typedef struct packed {
        logic signed [TW-1:0] re;
        logic signed [TW-1:0] im;
    } cplx_tw_t;

    typedef struct packed {
        logic signed [47:0] val;
        logic               ovf;
    } narrow_t;

    // cos/sin(2*pi*k/N_MAX) scaled by 256, round-to-nearest
    localparam logic signed [TW-1:0] COS_Q8 [N_MAX/2] = '{
        10'sd256,  10'sd255,  10'sd251,  10'sd245,  10'sd237,  10'sd226,  10'sd213,  10'sd198,
        10'sd181,  10'sd162,  10'sd142,  10'sd121,  10'sd98,   10'sd74,   10'sd50,   10'sd25,
        10'sd0,   -10'sd25,  -10'sd50,  -10'sd74,  -10'sd98,  -10'sd121, -10'sd142, -10'sd162,
       -10'sd181, -10'sd198, -10'sd213, -10'sd226, -10'sd237, -10'sd245, -10'sd251, -10'sd255
    };

    localparam logic signed [TW-1:0] SIN_Q8 [N_MAX/2] = '{
        10'sd0,    10'sd25,   10'sd50,   10'sd74,   10'sd98,   10'sd121,  10'sd142,  10'sd162,
        10'sd181,  10'sd198,  10'sd213,  10'sd226,  10'sd237,  10'sd245,  10'sd251,  10'sd255,
        10'sd256,  10'sd255,  10'sd251,  10'sd245,  10'sd237,  10'sd226,  10'sd213,  10'sd198,
        10'sd181,  10'sd162,  10'sd142,  10'sd121,  10'sd98,   10'sd74,   10'sd50,   10'sd25
    };

    function automatic logic signed [47:0] round_shift(input logic signed [47:0] v, input int frac);
        return (v + (48'sd1 <<< (frac - 1))) >>> frac;
    endfunction

    // Clamp to the signed dw-bit range when sat is set, otherwise keep the low dw bits.
    function automatic narrow_t narrow(input logic signed [47:0] v, input int dw, input bit sat);
        narrow_t r;
        logic signed [47:0] hi;
        logic signed [47:0] lo;
        hi    = (48'sd1 <<< (dw - 1)) - 48'sd1;
        lo    = -(48'sd1 <<< (dw - 1));
        r.val = v;
        r.ovf = 1'b0;
        if (sat) begin
            if (v > hi) begin
                r.val = hi;
                r.ovf = 1'b1;
            end else if (v < lo) begin
                r.val = lo;
                r.ovf = 1'b1;
            end
        end else begin
            r.val = (v <<< (48 - dw)) >>> (48 - dw);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup W_N^m = cos - i*sin, read from the N_MAX table at m*(N_MAX/N).
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [4:0]    m,
    output logic [TW-1:0] w_re,
    output logic [TW-1:0] w_im
);

    localparam logic [4:0] STEP = 5'(N_MAX / N);

    logic [4:0] idx;

    assign idx  = m * STEP;
    assign w_re = COS_Q8[idx];
    assign w_im = -SIN_Q8[idx];

endmodule

// File: rtl/fft_dif_stage.sv
// Pipelined radix-2 DIF butterfly: x = a + b, y = (a - b) * W_N^m, two register stages.
// Define FFT_STAGE_SAT_EN to saturate results and report ovf; otherwise results wrap and ovf is 0.
module fft_dif_stage
    import fft_pkg::*;
#(
    parameter int N     = 16,
    parameter int STAGE = 1,
    parameter int DW    = 16,
    parameter int FRAC  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2*DW-1:0] in_a,
    input  logic [2*DW-1:0] in_b,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2*DW-1:0] out_x,
    output logic [2*DW-1:0] out_y,
    output logic          out_last,
    output logic          frame_err,
    output logic          ovf
);

    localparam int JW   = $clog2(N) - 1;
    localparam int CW   = DW + 1;
    localparam int PW   = CW + TW + 1;
    localparam int SPAN = N >> (STAGE + 1);
    localparam logic [JW-1:0] J_LAST    = JW'(N / 2 - 1);
    localparam logic [JW-1:0] SPAN_MASK = JW'(SPAN - 1);
`ifdef FFT_STAGE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [JW-1:0]        j;
    logic                 accept;
    logic                 s1_valid, s1_last, s2_valid, s2_last;
    logic                 s1_adv, s2_adv;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic signed [CW-1:0] s_re, s_im, d_re, d_im;
    logic signed [TW-1:0] w_re, w_im;
    logic [TW-1:0]        rom_re, rom_im;
    logic [4:0]           tw_m;
    logic signed [PW-1:0] yr_full, yi_full;
    narrow_t              nx_re, nx_im, ny_re, ny_im;
    logic                 any_ovf;
    logic                 unused_bits;

    // Handshake: a beat moves when valid and ready are both high on a rising edge; each
    // register stage advances when empty or when the stage after it advances.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !clr;
    assign accept   = in_valid && in_ready;

    assign a_re = in_a[2*DW-1:DW];
    assign a_im = in_a[DW-1:0];
    assign b_re = in_b[2*DW-1:DW];
    assign b_im = in_b[DW-1:0];

    assign tw_m = 5'(j & SPAN_MASK) << STAGE;

    fft_twiddle_rom #(.N(N)) u_rom (
        .m    (tw_m),
        .w_re (rom_re),
        .w_im (rom_im)
    );

    // A misplaced in_last flags an error and restarts counting at the next beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j         <= '0;
            frame_err <= 1'b0;
        end else if (clr) begin
            j         <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            j <= (in_last || j == J_LAST) ? '0 : j + 1'b1;
            if (in_last && j != J_LAST) frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s_re     <= '0;
            s_im     <= '0;
            d_re     <= '0;
            d_im     <= '0;
            w_re     <= '0;
            w_im     <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s_re    <= CW'(a_re) + CW'(b_re);
                s_im    <= CW'(a_im) + CW'(b_im);
                d_re    <= CW'(a_re) - CW'(b_re);
                d_im    <= CW'(a_im) - CW'(b_im);
                w_re    <= rom_re;
                w_im    <= rom_im;
                s1_last <= (j == J_LAST);
            end
        end
    end

    always_comb begin
        yr_full = PW'(d_re) * PW'(w_re) - PW'(d_im) * PW'(w_im);
        yi_full = PW'(d_re) * PW'(w_im) + PW'(d_im) * PW'(w_re);
        nx_re   = narrow(48'(s_re), DW, SAT_EN);
        nx_im   = narrow(48'(s_im), DW, SAT_EN);
        ny_re   = narrow(round_shift(48'(yr_full), FRAC), DW, SAT_EN);
        ny_im   = narrow(round_shift(48'(yi_full), FRAC), DW, SAT_EN);
        any_ovf = nx_re.ovf | nx_im.ovf | ny_re.ovf | ny_im.ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            out_x    <= '0;
            out_y    <= '0;
        end else if (clr) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_x   <= {nx_re.val[DW-1:0], nx_im.val[DW-1:0]};
                out_y   <= {ny_re.val[DW-1:0], ny_im.val[DW-1:0]};
                s2_last <= s1_last;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_last  = s2_valid && s2_last;

`ifdef FFT_STAGE_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (s2_adv && s1_valid && any_ovf) begin
            ovf <= 1'b1;
        end
    end
    assign unused_bits = ^{nx_re.val[47:DW], nx_im.val[47:DW], ny_re.val[47:DW], ny_im.val[47:DW]};
`else
    assign ovf         = 1'b0;
    assign unused_bits = ^{nx_re.val[47:DW], nx_im.val[47:DW], ny_re.val[47:DW], ny_im.val[47:DW],
                           any_ovf};
`endif

endmodule
